// File: rtl/gameport_pkg.sv
// Shared constants, state type and target mapping for the game-port timer.
package gameport_pkg;

  localparam int DIR_R = 0;
  localparam int DIR_L = 1;
  localparam int DIR_D = 2;
  localparam int DIR_U = 3;
  localparam int BTN1  = 4;
  localparam int BTN2  = 5;

  localparam int GPIO_AXIS_LSB = 0;
  localparam int GPIO_BTN_LSB  = 4;

  typedef enum logic {IDLE, RUN} state_t;

  // Signed axis of width aw -> offset binary, zero-extended; caller truncates to CNT_W.
  function automatic logic [31:0] axis_target(input logic [31:0] a, input int aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (a ^ (32'd1 << (aw - 1))) & mask;
  endfunction

endpackage

// File: rtl/gameport_axis.sv
// One axis one-shot: live target compare and sticky bit.
// GAMEPORT_DIGITAL_EMU_EN enables digital-direction substitution for a centred axis.
module gameport_axis
  import gameport_pkg::*;
#(
  parameter int AXIS_W = 8,
  parameter int CNT_W  = 9
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [AXIS_W-1:0] analog,
  input  logic              dir_pos,
  input  logic              dir_neg,
  input  logic [CNT_W-1:0]  count,
  input  logic              start,
  input  logic              timeout,
  output logic              axis_bit
);

  logic [AXIS_W-1:0] eff;
  logic [CNT_W-1:0]  target;

`ifdef GAMEPORT_DIGITAL_EMU_EN
  always_comb begin
    eff = analog;
    // Only a centred stick takes the digital value; opposing presses cancel.
    if (analog == '0 && (dir_pos ^ dir_neg))
      eff = dir_pos ? {1'b0, {(AXIS_W-1){1'b1}}} : {1'b1, {(AXIS_W-1){1'b0}}};
  end
`else
  logic unused_dirs;
  assign unused_dirs = dir_pos ^ dir_neg;
  assign eff = analog;
`endif

  assign target = CNT_W'(axis_target(32'(eff), AXIS_W));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)                          axis_bit <= 1'b0;
    else if (start)                     axis_bit <= 1'b1;
    else if (timeout)                   axis_bit <= 1'b0;
    else if (axis_bit && count == target) axis_bit <= 1'b0;
  end

endmodule

// File: rtl/gameport_timer.sv
// Game-port (0x201) emulator top: FSM, prescaler, counter, stick swap and buttons.
// Optional digital-direction emulation via GAMEPORT_DIGITAL_EMU_EN.
module gameport_timer
  import gameport_pkg::*;
#(
  parameter int NUM_STICKS    = 2,
  parameter int AXIS_W        = 8,
  parameter int CNT_W         = 9,
  parameter int PRESCALE_BASE = 16
) (
  input  logic                           clk_sys,
  input  logic                           reset,
  input  logic [1:0]                     cpu_speed,
  input  logic                           swap,
  input  logic                           port_wr,
  input  logic [NUM_STICKS*2*AXIS_W-1:0] joy_analog,
  input  logic [NUM_STICKS*8-1:0]        joy_digital,
  output logic [7:0]                     gpio_dout,
  output logic [2*NUM_STICKS-1:0]        axis_bits,
  output logic [2*NUM_STICKS-1:0]        button_n,
  output logic                           busy
);

  localparam int PS_W = $clog2(PRESCALE_BASE * 4);

  state_t state, state_nx;
  logic [CNT_W-1:0] count;
  logic [PS_W-1:0]  presc, period_m1;
  logic [1:0]       spd;
  logic             tick, timeout;

  logic [NUM_STICKS-1:0][2*AXIS_W-1:0] ana_in, ana;
  logic [NUM_STICKS-1:0][7:0]          dig_in, dig;
  logic [2*NUM_STICKS-1:0]             btn_nx;
  logic                                unused_dig;

  assign ana_in = joy_analog;
  assign dig_in = joy_digital;

  always_comb begin
    ana = ana_in;
    dig = dig_in;
    if (swap) begin
      ana[0] = ana_in[1];
      ana[1] = ana_in[0];
      dig[0] = dig_in[1];
      dig[1] = dig_in[0];
    end
  end

  always_comb begin
    btn_nx     = '1;
    unused_dig = 1'b0;
    for (int s = 0; s < NUM_STICKS; s++) begin
      btn_nx[2*s]   = ~dig[s][BTN1];
      btn_nx[2*s+1] = ~dig[s][BTN2];
      unused_dig    = unused_dig ^ (^dig[s][7:6]);
    end
  end

  assign period_m1 = PS_W'(PRESCALE_BASE * (int'(spd) + 1) - 1);
  assign tick      = (state == RUN) && (presc == period_m1);
  // Counter reaching all-ones ends the run on the same edge it is loaded.
  assign timeout   = tick && (count == {{(CNT_W-1){1'b1}}, 1'b0});

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (port_wr) state_nx = RUN;
      RUN:  if (port_wr) state_nx = RUN;
            else if (timeout) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      count    <= '1;
      presc    <= '0;
      spd      <= 2'd0;
      button_n <= '1;
    end else begin
      button_n <= btn_nx;
      if (port_wr) begin
        count <= '0;
        presc <= '0;
        spd   <= cpu_speed;
      end else if (tick) begin
        count <= count + 1'b1;
        presc <= '0;
      end else if (state == RUN) begin
        presc <= presc + 1'b1;
      end
    end
  end

  for (genvar a = 0; a < 2*NUM_STICKS; a++) begin : g_axis
    localparam int S = a / 2;
    localparam int Y = a % 2;
    gameport_axis #(.AXIS_W(AXIS_W), .CNT_W(CNT_W)) u_axis (
      .clk_sys (clk_sys),
      .reset   (reset),
      .analog  (ana[S][Y*AXIS_W +: AXIS_W]),
      .dir_pos (Y ? dig[S][DIR_D] : dig[S][DIR_R]),
      .dir_neg (Y ? dig[S][DIR_U] : dig[S][DIR_L]),
      .count   (count),
      .start   (port_wr),
      .timeout (timeout),
      .axis_bit(axis_bits[a])
    );
  end

  assign busy = (state == RUN);
  assign gpio_dout[GPIO_AXIS_LSB +: 4] = axis_bits[3:0];
  assign gpio_dout[GPIO_BTN_LSB +: 4]  = button_n[3:0];

endmodule
